// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the rr_arbiter block.
//   arb_state_t      : arbiter FSM state (ARB_IDLE, ARB_GRANTED)
//   onehot_to_index  : index of the set bit in a one-hot vector
//   prio_mask        : mask of the ports strictly lower in priority than ptr
// The helpers work on MAX_PORTS-wide vectors. Callers zero-extend into them
// and cast the results back down, so an arbiter supports at most MAX_PORTS
// requesters.
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int MAX_PORTS = 32;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    // OR-ing the indices of all set bits gives the index of the single set
    // bit when the input is one-hot.
    function automatic int onehot_to_index(input logic [MAX_PORTS-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

    // With the LSB high, the ports below ptr in priority are those above it
    // in index. With the MSB high, they are the ports below it in index.
    function automatic logic [MAX_PORTS-1:0] prio_mask(input int ptr, input logic lsb_high);
        logic [MAX_PORTS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            mask[i] = lsb_high ? (i > ptr) : (i < ptr);
        end
        return mask;
    endfunction

endpackage

// File: rtl/rr_arbiter_priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder
// Combinational one-hot priority pick over a request vector.
//   request [WIDTH]  in   candidate requests
//   valid            out  any request present
//   onehot  [WIDTH]  out  highest-priority set bit of request, one-hot
// Parameter LSB_HIGH_PRIORITY: 1 = bit 0 wins, 0 = bit WIDTH-1 wins.
// ---------------------------------------------------------------------------
module priority_encoder
    import arb_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0] request,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    // Scan from lowest to highest priority. The last hit overwrites earlier
    // ones, so the highest-priority request is the one that survives.
    always_comb begin
        onehot = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (request[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (request[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end
    end

    assign valid = |request;

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Registered PORTS-way arbiter. It supports fixed or round-robin priority,
// an optional blocking grant released by acknowledge or by a dropped
// request, and an optional stuck-grant watchdog.
//   clk                     in   clock, rising edge
//   rst                     in   synchronous active-high reset
//   request       [PORTS]   in   level-sensitive requests
//   acknowledge   [PORTS]   in   release strobe; only the granted port's bit counts
//   grant         [PORTS]   out  one-hot registered grant
//   grant_valid             out  grant != 0
//   grant_encoded [IDX_W]   out  index of the granted port, 0 when idle
//   timeout                 out  one-cycle pulse when the watchdog forces a release
// Optional feature: define ARB_WATCHDOG_EN to build the watchdog.
// Without it, timeout is tied to 0 and TIMEOUT is ignored.
// PORTS must lie in 1..arb_pkg::MAX_PORTS.
// ---------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_BLOCK             = 0,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 0,
    parameter int TIMEOUT               = 256,
    localparam int IDX_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_encoded,
    output logic             timeout
);

    arb_state_t       state;
    logic             natural_release;
    logic             force_release;
    logic             rearb;
    logic [PORTS-1:0] arb_req;
    logic [PORTS-1:0] full_onehot;
    logic             full_valid;
    logic [PORTS-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;

    // Natural end of a blocking grant. grant is one-hot, so AND-ing with it
    // selects only the winner's acknowledge or request bit.
    always_comb begin
        if (ARB_BLOCK_ACK != 0) begin
            natural_release = |(acknowledge & grant);
        end else begin
            natural_release = ~|(request & grant);
        end
    end

    // Arbitrate when idle, on every cycle in non-blocking mode, or when the
    // current holder lets go.
    assign rearb = (state == ARB_IDLE) || (ARB_BLOCK == 0) || natural_release || force_release;

    // A port released by the watchdog is excluded from the same-cycle pick.
    // The grant then moves on, or drops to idle if nobody else is asking.
    assign arb_req = force_release ? (request & ~grant) : request;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_full (
        .request (arb_req),
        .valid   (full_valid),
        .onehot  (full_onehot)
    );

    generate
        if (ARB_TYPE_ROUND_ROBIN != 0) begin : g_rr
            logic [IDX_W-1:0] last_ptr;
            logic [PORTS-1:0] lower_mask;
            logic [PORTS-1:0] masked_req;
            logic [PORTS-1:0] masked_onehot;
            logic             masked_valid;

            assign lower_mask = PORTS'(prio_mask(int'(last_ptr), ARB_LSB_HIGH_PRIORITY != 0));
            assign masked_req = arb_req & lower_mask;

            priority_encoder #(
                .WIDTH             (PORTS),
                .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
            ) u_enc_masked (
                .request (masked_req),
                .valid   (masked_valid),
                .onehot  (masked_onehot)
            );

            // Prefer requesters below the last winner. If none are pending,
            // wrap around to the full vector.
            assign win_onehot = masked_valid ? masked_onehot : full_onehot;

            // The pointer only moves when a grant is actually issued.
            always_ff @(posedge clk) begin
                if (rst) begin
                    last_ptr <= '0;
                end else if (rearb && full_valid) begin
                    last_ptr <= win_idx;
                end
            end
        end else begin : g_fixed
            assign win_onehot = full_onehot;
        end
    endgenerate

    assign win_idx = IDX_W'(onehot_to_index(MAX_PORTS'(win_onehot)));

    // Main FSM and output registers. Every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
        end else if (rearb) begin
            if (full_valid) begin
                state         <= ARB_GRANTED;
                grant         <= win_onehot;
                grant_valid   <= 1'b1;
                grant_encoded <= win_idx;
            end else begin
                state         <= ARB_IDLE;
                grant         <= '0;
                grant_valid   <= 1'b0;
                grant_encoded <= '0;
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [WD_W-1:0] wd_count;

    // The watchdog fires only while a blocking grant is held and has not
    // ended naturally in this cycle.
    assign force_release = (ARB_BLOCK != 0) && (state == ARB_GRANTED) && !natural_release &&
                           (wd_count == WD_W'(TIMEOUT - 1));

    // The counter restarts on every arbitration and otherwise counts held
    // cycles. The release at TIMEOUT-1 keeps it from ever overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_release;
            if (rearb) begin
                wd_count <= '0;
            end else begin
                wd_count <= wd_count + WD_W'(1);
            end
        end
    end
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

endmodule
